// File: rtl/wide_adder_sequencer_if.sv
// Request/result bus between a requesting master and wide_adder_sequencer.
// The master drives operands and start; the sequencer returns status and the registered result.
interface wide_adder_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    logic                   start;
    logic                   sub;
    logic                   cin;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   sum;
    logic                   cout;
    logic                   overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/wide_adder_sequencer.sv
// Multi-cycle 4*NIBBLES-bit add/subtract built around one shared 4-bit full adder.
// Nibbles are processed LSB first, one per clock, with the carry registered between slices.
module wide_adder_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wide_adder_sequencer_if.slave bus
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    // Shared 4-bit ripple-carry adder slice
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_s;
    logic [4:0] add_rc;
    logic       add_c;

    assign add_a = a_q[4*idx_q +: 4];
    assign add_b = b_q[4*idx_q +: 4];

    always_comb begin
        add_rc    = '0;
        add_s     = '0;
        add_rc[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            add_s[i]    = add_a[i] ^ add_b[i] ^ add_rc[i];
            add_rc[i+1] = (add_a[i] & add_b[i]) | (add_rc[i] & (add_a[i] ^ add_b[i]));
        end
    end

    assign add_c = add_rc[4];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            RUN: begin
                sum_d[4*idx_q +: 4] = add_s;
                carry_d             = add_c;
                if (idx_q == LAST) begin
                    state_d = FIN;
                    idx_d   = '0;
                    cout_d  = add_c;
                    // add_s[3] is the MSB of the sum being written on this edge
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // IDLE and FIN both accept; FIN accepting gives back-to-back operation
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == FIN);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// Directed bench for wide_adder_sequencer with a cycle model and result scoreboard.
module tb_wide_adder_sequencer;
    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } result_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   mon_en;

    result_t exp_q[$];
    int      m_state;  // 0 idle, 1 run, 2 fin
    int      m_cnt;

    wide_adder_sequencer_if #(.NIBBLES(N)) bus ();

    wide_adder_sequencer #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub, input logic cin);
        logic [W:0]   full;
        logic [W-1:0] be;
        result_t      r;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    // Bench-side cycle model: decides accepts from its own state and the driven inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            exp_q.delete();
        end else if (m_state == 1) begin
            if (m_cnt == N - 1) m_state <= 2;
            else m_cnt <= m_cnt + 1;
        end else if (bus.start) begin
            exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
            m_state <= 1;
            m_cnt   <= 0;
        end else begin
            m_state <= 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("busy", 32'(bus.busy), 32'(m_state == 1));
            check("done", 32'(bus.done), 32'(m_state == 2));
            if (m_state == 2) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    result_t r;
                    r = exp_q.pop_front();
                    check("sb_sum", 32'(bus.sum), 32'(r.sum));
                    check("sb_cout", 32'(bus.cout), 32'(r.cout));
                    check("sb_overflow", 32'(bus.overflow), 32'(r.ovf));
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.cin   = cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.sub   = ~sub;
        bus.cin   = ~cin;
        repeat (N + 1) @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] s,
                                input logic c, input logic o);
        check({tag, "_sum"}, 32'(bus.sum), 32'(s));
        check({tag, "_cout"}, 32'(bus.cout), 32'(c));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(o));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check_result(tag, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int wait_cnt;
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        #12;
        check_cleared("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_cleared("idle");

        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        check_result("add", 16'h2233, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check_result("wrap", 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check_result("sovf", 16'h8000, 1'b0, 1'b1);
        do_op(16'h1000, 16'h0FFF, 1'b0, 1'b1);
        check_result("addcin", 16'h2000, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        check_result("sub", 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        check_result("subovf", 16'h7FFF, 1'b1, 1'b1);

        // Continuous start with operands changing every cycle
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        for (int i = 0; i < 22; i++) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.sub = 1'($urandom);
            bus.cin = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_cnt  = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Abort during the second RUN cycle
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'h4321;
        bus.b     = 16'h1111;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_cleared("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (N + 2) @(posedge clk);
        #1;
        check_cleared("abort_hold");

        do_op(16'h4321, 16'h1111, 1'b0, 1'b0);
        check_result("post_abort", 16'h5432, 1'b0, 1'b0);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wide_adder_sequencer.md
Name: wide_adder_sequencer

Overview:
- Multi-cycle controller that performs a 4*NIBBLES-bit add or subtract using a single instance of the team's four_bit_full_adder.
- Operands are processed least-significant nibble first, one nibble per clock, with the carry held in a register between cycles.
- Sits between a requesting master (start/done handshake) and the shared 4-bit adder datapath, trading latency for area.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
sub  input  1  0 = a+b+cin; 1 = a-b (b inverted, carry-in forced 1, cin ignored)
cin  input  1  carry-in for add mode
a  input  W  operand A, sampled on accept edge
b  input  W  operand B, sampled on accept edge
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
sum  output  W  result register
cout  output  1  carry out of MSB nibble (sub mode: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; nibble index=0; carry reg=0; operand regs=0. Reset asserted mid-operation aborts immediately; no done is produced.
- States: IDLE, RUN, FIN.
- IDLE: on the edge with start=1, accept the request:
  - latch a into A_r.
  - latch b into B_r; B_r = ~b when sub=1.
  - carry reg = sub ? 1 : cin.
  - index = 0; go to RUN.
- RUN: each edge does all of the following, then index++:
  - drives nibble[index] of A_r and B_r plus the carry reg into the adder.
  - writes the adder sum into sum[4*index+3:4*index].
  - writes the adder carry into the carry reg.
- RUN exit: on the edge where index = NIBBLES-1, go to FIN and register:
  - cout = adder carry.
  - overflow = (A_r[W-1] == B_r[W-1]) && (new sum[W-1] != A_r[W-1]).
- FIN: lasts exactly one cycle; done=1, busy=0. Next edge goes to IDLE, or straight into an accept if start=1 (back-to-back supported).
- busy: 1 in RUN only. done: 1 in FIN only.
- Latency: accept edge E0; sum, cout and overflow are final after edge E(NIBBLES); done is high during cycle E(NIBBLES)..E(NIBBLES+1).
- Throughput: one result per NIBBLES+1 cycles.
- start while busy=1 is ignored; no queueing. Changes on a, b, sub or cin after accept have no effect.
- sum, cout and overflow hold their last values from FIN until the first RUN edge of the next operation. cout and overflow are updated only at RUN exit.
- Upper sum nibbles hold stale data while RUN is in progress; consumers use sum only when done=1.
- Wrap-around: results are modulo 2^W; carry/borrow is reported only via cout.

Test Plan:
- Reset then idle, NIBBLES=4: all outputs 0; start held 0 for 10 cycles -> busy and done never assert.
- Add: a=0x1234, b=0x0FFF, cin=0, sub=0, start pulse -> busy for 4 cycles, then done 1 cycle; sum=0x2233, cout=0, overflow=0.
- Wrap: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, overflow=0. Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
- Protocol: start held high continuously with operands changed every cycle -> only the values present on accept edges are used; results arrive every 5 cycles; done is a single-cycle pulse each time.
- Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle -> outputs clear immediately, no done pulse; the next start yields the correct result.
